simon_pipeline: RTL and testbench

Fully pipelined Simon 32/64 block-cipher encryptor: 32-bit block, 64-bit key, 32 rounds, one round per pipeline stage, with round keys expanded inside the pipeline alongside the data. It accepts a new plaintext/key pair every clock and produces one ciphertext per clock after a fixed latency. It serves as the encryption datapath for the crypto subsystem.

---
 rtl/simon_pkg.sv | 61 ++++++
 rtl/simon_round_stage.sv | 55 +++++
 rtl/simon_pipeline.sv | 53 +++++
 tb/tb_simon_pipeline.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : simon_pkg
//  Description: Constants and round / key-schedule helper functions for the
//               Simon 32/64 encryption pipeline.
//  Revision   : 1.0 - initial release
// ============================================================================
package simon_pkg;

  localparam int WORD_W    = 16;
  localparam int KEY_WORDS = 4;
  localparam int ROUNDS    = 32;

  localparam logic [WORD_W-1:0] C = 16'hFFFC;

  // Leftmost character of the z0 sequence is bit 61, so z0[i] = Z0[61-i].
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // Circular rotate left by n (n in 1..15).
  function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] v,
                                              input int n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  // Circular rotate right by n (n in 1..15).
  function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] v,
                                              input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  // Nonlinear Feistel function f(x) = (S1 x & S8 x) ^ S2 x.
  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
    return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
  endfunction

  // One round on the block {x, y} with round key k.
  function automatic logic [2*WORD_W-1:0] simon_round(
      input logic [2*WORD_W-1:0] d,
      input logic [WORD_W-1:0]   k);
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    x = d[2*WORD_W-1:WORD_W];
    y = d[WORD_W-1:0];
    return {y ^ simon_f(x) ^ k, x};
  endfunction

  // Advance the key window {k_{i+3}, k_{i+2}, k_{i+1}, k_i} by one word,
  // producing {k_{i+4}, k_{i+3}, k_{i+2}, k_{i+1}}.
  function automatic logic [KEY_WORDS*WORD_W-1:0] key_step(
      input logic [KEY_WORDS*WORD_W-1:0] win,
      input logic [5:0]                  idx);
    logic [WORD_W-1:0] t;
    logic [WORD_W-1:0] k_new;
    t     = ror16(win[63:48], 3) ^ win[31:16];
    k_new = C ^ {{(WORD_W-1){1'b0}}, Z0[6'd61 - idx]} ^ win[15:0] ^ t ^ ror16(t, 1);
    return {k_new, win[63:16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_round_stage.sv
`default_nettype none
// ============================================================================
//  Module     : simon_round_stage
//  Description: One Simon 32/64 pipeline stage: applies round ROUND_IDX to the
//               block, advances the key window and forwards the valid bit.
//               The final stage only loads its data on a valid block so the
//               ciphertext holds across bubbles.
//  Revision   : 1.0 - initial release
// ============================================================================
module simon_round_stage
  import simon_pkg::*;
#(
  parameter int ROUND_IDX = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [2*WORD_W-1:0]           i_data,
  input  logic [KEY_WORDS*WORD_W-1:0]   i_key,
  output logic                          o_valid,
  output logic [2*WORD_W-1:0]           o_data,
  output logic [KEY_WORDS*WORD_W-1:0]   o_key
);

  localparam bit         c_LAST_STAGE = (ROUND_IDX == ROUNDS - 1);
  localparam logic [5:0] c_IDX        = 6'(ROUND_IDX);

  logic                        r_valid;
  logic [2*WORD_W-1:0]         r_data;
  logic [KEY_WORDS*WORD_W-1:0] r_key;
  logic                        w_load;

  assign w_load = c_LAST_STAGE ? i_valid : 1'b1;

  // Stage registers: round function and key step run side by side.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_key   <= '0;
    end else begin
      r_valid <= i_valid;
      r_key   <= key_step(i_key, c_IDX);
      if (w_load) begin
        r_data <= simon_round(i_data, i_key[WORD_W-1:0]);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_key   = r_key;

endmodule
`default_nettype wire

// File: rtl/simon_pipeline.sv
`default_nettype none
// ============================================================================
//  Module     : simon_pipeline
//  Description: Fully pipelined Simon 32/64 encryptor, one round per stage,
//               round keys expanded in-line with the data. Accepts one block
//               per clock; ciphertext is the final stage's data register.
//  Revision   : 1.0 - initial release
// ============================================================================
module simon_pipeline
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] keytext,
  input  logic [31:0] plaintext,
  output logic [31:0] ciphertext
);

  // Index 0 is the input side, index s is the output of stage s.
  logic                        w_valid [0:ROUNDS];
  logic [2*WORD_W-1:0]         w_data  [0:ROUNDS];
  logic [KEY_WORDS*WORD_W-1:0] w_key   [0:ROUNDS];
  logic                        w_unused_tail;

  assign w_valid[0] = start;
  assign w_data[0]  = plaintext;
  assign w_key[0]   = keytext;

  generate
    for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_stage
      simon_round_stage #(
        .ROUND_IDX (gi)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_valid[gi]),
        .i_data  (w_data[gi]),
        .i_key   (w_key[gi]),
        .o_valid (w_valid[gi+1]),
        .o_data  (w_data[gi+1]),
        .o_key   (w_key[gi+1])
      );
    end
  endgenerate

  // The last stage's key window and valid bit have no consumer.
  assign w_unused_tail = ^{w_key[ROUNDS], w_valid[ROUNDS]};

  assign ciphertext = w_data[ROUNDS];

endmodule
`default_nettype wire

// File: tb/tb_simon_pipeline.sv
`default_nettype none
// ============================================================================
//  Module     : tb_simon_pipeline
//  Description: Directed self-checking bench for simon_pipeline.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_simon_pipeline;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] keytext;
  logic [31:0] plaintext;
  logic [31:0] ciphertext;

  int checks;
  int failures;

  localparam logic [63:0] KEY_A = 64'h1918111009080100;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;

  simon_pipeline dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .keytext    (keytext),
    .plaintext  (plaintext),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Simon 32/64: full key expansion, then 32 rounds.
  function automatic logic [31:0] model(input logic [63:0] key, input logic [31:0] pt);
    string       z;
    logic [15:0] k [0:31];
    logic [15:0] x, y, tmp, zb;
    z = "11111010001001010110000111001101111101000100101011000011100110";
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 4; i < 32; i++) begin
      tmp  = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
      tmp  = tmp ^ {tmp[0], tmp[15:1]};
      zb   = (z.getc(i-4) == "1") ? 16'd1 : 16'd0;
      k[i] = ~k[i-4] ^ tmp ^ zb ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    tick(2);
    checks++;
    if (ciphertext !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", ciphertext, 32'h0);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (ciphertext !== 32'h0) begin
      failures++;
      $display("FAIL reset_release: got %h expected %h", ciphertext, 32'h0);
    end
  endtask

  task automatic test_standard_vector();
    start = 1'b1;
    keytext = KEY_A;
    plaintext = 32'h65656877;
    tick(1);                // edge E
    start = 1'b0;
    plaintext = 32'h0;
    tick(30);               // edge E+30
    checks++;
    if (ciphertext !== 32'h0) begin
      failures++;
      $display("FAIL std_early: got %h expected %h", ciphertext, 32'h0);
    end
    tick(1);                // edge E+31
    checks++;
    if (ciphertext !== 32'hC69BE9BB) begin
      failures++;
      $display("FAIL std_vector: got %h expected %h", ciphertext, 32'hC69BE9BB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pts [0:2];
    logic [31:0] exp_ct;
    pts[0] = 32'h41424344;
    pts[1] = 32'h345A6B7C;
    pts[2] = 32'h78569043;
    keytext = KEY_A;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      plaintext = pts[i];
      tick(1);
    end
    start = 1'b0;
    tick(29);               // first block's edge E+31
    for (int i = 0; i < 3; i++) begin
      exp_ct = model(KEY_A, pts[i]);
      checks++;
      if (ciphertext !== exp_ct) begin
        failures++;
        $display("FAIL b2b_%0d: got %h expected %h", i, ciphertext, exp_ct);
      end
      if (i < 2) tick(1);
    end
    tick(1);
    exp_ct = model(KEY_A, pts[2]);
    checks++;
    if (ciphertext !== exp_ct) begin
      failures++;
      $display("FAIL b2b_hold: got %h expected %h", ciphertext, exp_ct);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] exp_a, exp_b;
    exp_a = model(KEY_A, 32'h11223344);
    exp_b = model(KEY_A, 32'hDEADBEEF);
    keytext = KEY_A;
    start = 1'b1;
    plaintext = 32'h11223344;
    tick(1);                // E
    start = 1'b0;
    plaintext = 32'hFFFFFFFF;
    tick(5);                // E+5
    start = 1'b1;
    plaintext = 32'hDEADBEEF;
    tick(1);                // E+6
    start = 1'b0;
    tick(25);               // E+31
    checks++;
    if (ciphertext !== exp_a) begin
      failures++;
      $display("FAIL bubble_first: got %h expected %h", ciphertext, exp_a);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (ciphertext !== exp_a) begin
        failures++;
        $display("FAIL bubble_hold_%0d: got %h expected %h", i, ciphertext, exp_a);
      end
    end
    tick(1);                // E+37
    checks++;
    if (ciphertext !== exp_b) begin
      failures++;
      $display("FAIL bubble_second: got %h expected %h", ciphertext, exp_b);
    end
  endtask

  task automatic test_key_change();
    logic [63:0] keys [0:3];
    logic [31:0] pts  [0:3];
    logic [31:0] exp_ct;
    keys[0] = KEY_A; keys[1] = KEY_B; keys[2] = KEY_A; keys[3] = KEY_B;
    pts[0] = 32'h65656877; pts[1] = 32'h65656877;
    pts[2] = 32'hCAFEF00D; pts[3] = 32'h00000000;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      keytext = keys[i];
      plaintext = pts[i];
      tick(1);
    end
    start = 1'b0;
    keytext = 64'h0;
    tick(28);               // first block's edge E+31
    for (int i = 0; i < 4; i++) begin
      exp_ct = model(keys[i], pts[i]);
      checks++;
      if (ciphertext !== exp_ct) begin
        failures++;
        $display("FAIL keychg_%0d: got %h expected %h", i, ciphertext, exp_ct);
      end
      if (i < 3) tick(1);
    end
  endtask

  task automatic test_reset_midflight();
    bit leaked;
    keytext = KEY_A;
    start = 1'b1;
    plaintext = 32'h0BADC0DE;
    tick(1);
    start = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (ciphertext !== 32'h0) begin
      failures++;
      $display("FAIL midrst_clear: got %h expected %h", ciphertext, 32'h0);
    end
    leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ciphertext !== 32'h0) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL midrst_no_output: got %h expected %h", ciphertext, 32'h0);
    end
  endtask

  task automatic test_reset_collision();
    bit leaked;
    rst = 1'b1;
    start = 1'b1;
    keytext = KEY_A;
    plaintext = 32'h65656877;
    tick(1);
    rst = 1'b0;
    start = 1'b0;
    leaked = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tick(1);
      if (ciphertext !== 32'h0) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL collision_ignored: got %h expected %h", ciphertext, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    keytext = 64'h0;
    plaintext = 32'h0;
    test_reset();
    test_standard_vector();
    test_back_to_back();
    test_bubble();
    test_key_change();
    test_reset_midflight();
    test_reset_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
